// File: rtl/data_mem_mp.sv
// rtl/data_mem_mp.sv - two-read/one-masked-write data memory with hardware clear engine.
// Optional macro DATA_MEM_MP_BYPASS_EN forwards a same-cycle write to matching read ports.
module data_mem_mp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    output logic              busy,
    output logic              clr_done,
    output logic              addr_err
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_PRE  = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] storage [DEPTH];

    logic              idle;
    logic              rd1_ok;
    logic              rd2_ok;
    logic              wr_ok;
    logic              do_rd;
    logic              do_wr;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] word1;
    logic [DATA_W-1:0] word2;

    assign idle        = (state == IDLE);
    assign rd1_ok      = ({1'b0, rd_addr1} < DEPTH_X);
    assign rd2_ok      = ({1'b0, rd_addr2} < DEPTH_X);
    assign wr_ok       = ({1'b0, wr_addr} < DEPTH_X);
    assign do_rd       = idle & rd_en;
    assign do_wr       = idle & wr_en & wr_ok;
    assign merged_word = (storage[wr_addr] & ~wr_mask) | (wr_data & wr_mask);

    always_comb begin
        word1 = rd1_ok ? storage[rd_addr1] : '0;
        word2 = rd2_ok ? storage[rd_addr2] : '0;
`ifdef DATA_MEM_MP_BYPASS_EN
        if (do_wr && rd_addr1 == wr_addr) word1 = merged_word;
        if (do_wr && rd_addr2 == wr_addr) word2 = merged_word;
`endif
    end

    // Array has no reset; the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            storage[cnt] <= '0;
        end else if (do_wr) begin
            storage[wr_addr] <= merged_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            clr_done <= 1'b0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            addr_err <= idle & ((rd_en & ~(rd1_ok & rd2_ok)) | (wr_en & ~wr_ok));
            if (do_rd) begin
                rd_data1 <= word1;
                rd_data2 <= word2;
            end
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt      <= cnt + 1'b1;
                    clr_done <= (cnt == CNT_PRE);
                    if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_mp.sv
// tb/tb_data_mem_mp.sv - scoreboard bench for data_mem_mp at DEPTH 64 and DEPTH 40.
module tb_data_mem_mp;
    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_req = 1'b0;
    logic       rd_en = 1'b0;
    logic [5:0] rd_addr1 = '0;
    logic [5:0] rd_addr2 = '0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] wr_mask = '0;

    logic [7:0] d1 [2];
    logic [7:0] d2 [2];
    logic       valid [2];
    logic       busy [2];
    logic       done [2];
    logic       err [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_mp #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) u64 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_data1(d1[0]), .rd_data2(d2[0]),
        .rd_valid(valid[0]), .busy(busy[0]), .clr_done(done[0]), .addr_err(err[0])
    );

    data_mem_mp #(.DATA_W(8), .ADDR_W(6), .DEPTH(40)) u40 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_data1(d1[1]), .rd_data2(d2[1]),
        .rd_valid(valid[1]), .busy(busy[1]), .clr_done(done[1]), .addr_err(err[1])
    );

    // Reference model: a plain word array and a "clear cycles remaining" count per instance.
    logic [7:0] mm [2][64];
    int         clr_left [2];
    int         dep [2] = '{64, 40};
    logic       e_busy [2];
    logic       e_done [2];
    logic       e_err [2];
    logic       e_valid [2];
    resp_t      q0 [$];
    resp_t      q1 [$];
    logic [7:0] hold1 [2];
    logic [7:0] hold2 [2];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            clr_left[i] = dep[i];
            e_busy[i] = 1'b1; e_done[i] = 1'b0; e_err[i] = 1'b0; e_valid[i] = 1'b0;
            hold1[i] = '0; hold2[i] = '0;
            for (int a = 0; a < 64; a++) mm[i][a] = '0;
        end
    end

    // Model step: inputs are stable here and take effect at the coming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            for (int i = 0; i < 2; i++) begin
                e_valid[i] = 1'b0;
                e_err[i]   = 1'b0;
                if (rst) begin
                    clr_left[i] = dep[i];
                end else if (clr_left[i] > 0) begin
                    mm[i][dep[i] - clr_left[i]] = 8'h00;
                    clr_left[i]--;
                end else begin
                    bit ok1, ok2, okw;
                    logic [7:0] nw;
                    resp_t r;
                    ok1 = int'(rd_addr1) < dep[i];
                    ok2 = int'(rd_addr2) < dep[i];
                    okw = int'(wr_addr) < dep[i];
                    nw  = (mm[i][wr_addr] & ~wr_mask) | (wr_data & wr_mask);
                    if (rd_en) begin
                        r.d1 = ok1 ? mm[i][rd_addr1] : 8'h00;
                        r.d2 = ok2 ? mm[i][rd_addr2] : 8'h00;
`ifdef DATA_MEM_MP_BYPASS_EN
                        if (wr_en && okw && rd_addr1 == wr_addr) r.d1 = nw;
                        if (wr_en && okw && rd_addr2 == wr_addr) r.d2 = nw;
`endif
                        if (i == 0) q0.push_back(r); else q1.push_back(r);
                    end
                    e_valid[i] = rd_en;
                    e_err[i]   = (rd_en && !(ok1 && ok2)) || (wr_en && !okw);
                    if (wr_en && okw) mm[i][wr_addr] = nw;
                    if (clr_req) clr_left[i] = dep[i];
                end
                e_busy[i] = clr_left[i] > 0;
                e_done[i] = clr_left[i] == 1;
            end
        end
    end

    // Monitor: compares DUT outputs after each rising edge; read data comes off the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), busy[i], e_busy[i]);
                chk($sformatf("clr_done[%0d]", i), done[i], e_done[i]);
                chk($sformatf("addr_err[%0d]", i), err[i], e_err[i]);
                chk($sformatf("rd_valid[%0d]", i), valid[i], e_valid[i]);
                if (rst) begin
                    hold1[i] = '0;
                    hold2[i] = '0;
                end
                if (valid[i] === 1'b1) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("scoreboard_nonempty[%0d]", i), 0, 1);
                    end else begin
                        resp_t r;
                        r = (i == 0) ? q0.pop_front() : q1.pop_front();
                        hold1[i] = r.d1;
                        hold2[i] = r.d2;
                    end
                end
                chk($sformatf("rd_data1[%0d]", i), d1[i], hold1[i]);
                chk($sformatf("rd_data2[%0d]", i), d2[i], hold2[i]);
            end
        end
    end

    task automatic cyc(input logic r, input logic cr, input logic re, input int a1, input int a2,
                       input logic we, input int wa, input int wd, input int wm);
        @(negedge clk);
        #1;
        rst = r; clr_req = cr; rd_en = re;
        rd_addr1 = 6'(a1); rd_addr2 = 6'(a2);
        wr_en = we; wr_addr = 6'(wa); wr_data = 8'(wd); wr_mask = 8'(wm);
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_n(66);
        cyc(0, 0, 1, 0, 31, 0, 0, 0, 0);
        cyc(0, 0, 1, 63, 39, 0, 0, 0, 0);
        // Basic write/read then hold.
        cyc(0, 0, 0, 0, 0, 1, 5, 'hA5, 'hFF);
        cyc(0, 0, 1, 5, 6, 0, 0, 0, 0);
        idle_n(3);
        // Masked write.
        cyc(0, 0, 0, 0, 0, 1, 9, 'hF0, 'hFF);
        cyc(0, 0, 0, 0, 0, 1, 9, 'h0F, 'h3C);
        cyc(0, 0, 1, 9, 9, 0, 0, 0, 0);
        // Read during write.
        cyc(0, 0, 0, 0, 0, 1, 2, 'h11, 'hFF);
        cyc(0, 0, 1, 2, 2, 1, 2, 'h77, 'hFF);
        cyc(0, 0, 1, 2, 2, 0, 0, 0, 0);
        // Activity while clearing is ignored.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle_n(10);
        cyc(0, 1, 1, 0, 5, 1, 0, 'h55, 'hFF);
        idle_n(66);
        cyc(0, 0, 1, 0, 5, 0, 0, 0, 0);
        // Reset mid-clear restarts the engine.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle_n(10);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_n(66);
        // Out of range for the DEPTH 40 instance.
        cyc(0, 0, 0, 0, 0, 1, 3, 'h9E, 'hFF);
        cyc(0, 0, 1, 45, 3, 1, 45, 'h3C, 'hFF);
        cyc(0, 0, 1, 45, 45, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 50, 'h3C, 'hFF);
        idle_n(2);
        for (int k = 0; k < 2500; k++) begin
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 79) == 0),
                $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 255),
                ($urandom_range(0, 3) == 0) ? 'hFF : $urandom_range(0, 255));
        end
        idle_n(4);
        chk("scoreboard_drained[0]", q0.size(), 0);
        chk("scoreboard_drained[1]", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
